reg_pair_sequencer: RTL and testbench
=====================================

# reg_pair_sequencer

- Issues byte-wide read/write strobes to the 8-entry `register_file` so the GB80 core can access 16-bit register pairs.
- Supports four pair operations: read, write, increment and decrement.
- Sits between the instruction decode/control unit and `register_file`.
- Serializes each pair operation into high-byte and low-byte register-file accesses behind a valid/ready command handshake, and pulses a completion strobe carrying the 16-bit result.

## Interface
Reset is synchronous and active-high; the block uses one clock.

Parameters:
- `DATA_WIDTH`, default 8: register-file byte width; pair width is 2*DATA_WIDTH.
- `ADDRESS_WIDTH`, default 3: register-file address width.
- `F_MASK`, default 8'hF0: AND-mask applied to every byte written to F (address 6).

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  command accepted when high together with `i_cmd_valid`.
- `i_cmd`  in  2  operation: 00 READ, 01 WRITE, 10 INC, 11 DEC.
- `i_pair`  in  2  pair select: 00 BC (hi 0, lo 1), 01 DE (2, 3), 10 HL (4, 5), 11 AF (hi 7, lo 6).
- `i_wdata`  in  2*DATA_WIDTH  WRITE data, {hi, lo}.
- `o_done`  out  1  one-cycle completion pulse.
- `o_result`  out  2*DATA_WIDTH  pair value; valid while `o_done` is high.
- `o_rf_rd_en`  out  1  register-file read strobe.
- `o_rf_wr_en`  out  1  register-file write strobe.
- `o_rf_addr`  out  ADDRESS_WIDTH  register-file address.
- `o_rf_data`  out  DATA_WIDTH  register-file write data.
- `i_rf_data`  in  DATA_WIDTH  register-file read data; valid in the cycle after `o_rf_rd_en`.

## Operation
States: IDLE, RD_HI, RD_LO, CAP_LO, WR_HI, WR_LO, DONE.

- **IDLE**
  - `o_cmd_ready`=1.
  - When `i_cmd_valid`=1, latch `i_cmd`, `i_pair` and `i_wdata`.
  - WRITE goes to WR_HI; READ, INC and DEC go to RD_HI.
  - Inputs are ignored outside the acceptance edge.
- **RD_HI**: `o_rf_rd_en`=1, `o_rf_addr`=hi address; go to RD_LO.
- **RD_LO**: `o_rf_rd_en`=1, `o_rf_addr`=lo address; capture `i_rf_data` as hi byte; go to CAP_LO.
- **CAP_LO**
  - No strobes.
  - Capture `i_rf_data` as lo byte.
  - Compute result: READ uses {hi, lo}; INC uses {hi, lo}+1; DEC uses {hi, lo}-1.
  - Arithmetic is modulo 2^(2*DATA_WIDTH): 16'hFFFF+1 = 16'h0000 and 16'h0000-1 = 16'hFFFF. No flags are produced or modified.
  - READ goes to DONE; INC and DEC go to WR_HI.
- **WR_HI**: `o_rf_wr_en`=1, `o_rf_addr`=hi address, `o_rf_data`=result[15:8]; go to WR_LO.
- **WR_LO**: `o_rf_wr_en`=1, `o_rf_addr`=lo address, `o_rf_data`=result[7:0], with `F_MASK` applied when the lo address is 6; go to DONE.
- **DONE**
  - `o_done`=1.
  - `o_result` equals the value now held by the pair, including the F mask for AF writes; for READ it is the raw value read.
  - Go to IDLE.

Output rules:
- `o_rf_rd_en` and `o_rf_wr_en` are never high in the same cycle.
- `o_rf_addr` and `o_rf_data` are 0 whenever no strobe is active.
- `o_result` holds its last value outside DONE.

Reset:
- All outputs are 0 except `o_cmd_ready`=1 (IDLE); `o_result`=0; state is IDLE.
- Reset asserted mid-operation aborts it immediately: no further strobes and no `o_done`.
- A hi byte already written stays written; the caller must reissue the command.

## Timing
Cycle 0 is the acceptance cycle (`i_cmd_valid` & `o_cmd_ready` at the rising edge ending cycle 0).

- READ:
  - `o_rf_rd_en` high in cycle 1 (hi) and cycle 2 (lo).
  - `o_done` in cycle 4.
- WRITE:
  - `o_rf_wr_en` in cycle 1 (hi) and cycle 2 (lo).
  - `o_done` in cycle 3.
- INC/DEC:
  - Reads in cycles 1 and 2.
  - Writes in cycles 4 (hi) and 5 (lo).
  - `o_done` in cycle 6.
- Throughput:
  - `o_cmd_ready` is low from cycle 1 through the DONE cycle and returns to 1 in the cycle after DONE.
  - Back-to-back commands are therefore spaced by op latency + 1 cycles.
- `i_cmd_valid` held high during busy cycles is not accepted and causes no side effects.

## Test plan
- **Reset then READ**
  - Stimulus: reset; preload reg4=8'h12, reg5=8'h34; issue READ HL.
  - Required: reads at addr 4 then 5 in cycles 1 and 2; `o_done` in cycle 4 with `o_result`=16'h1234; no writes.
- **WRITE AF with mask**
  - Stimulus: issue WRITE AF with `i_wdata`=16'hABCD.
  - Required: writes addr 7 = 8'hAB in cycle 1, addr 6 = 8'hC0 in cycle 2; `o_done` in cycle 3 with `o_result`=16'hABC0.
- **INC wrap**
  - Stimulus: BC=16'hFFFF; issue INC BC.
  - Required: writes addr 0 = 8'h00 in cycle 4, addr 1 = 8'h00 in cycle 5; `o_done` in cycle 6 with `o_result`=16'h0000.
- **DEC borrow and wrap**
  - Stimulus: DE=16'h0100, then DEC DE; next DE=16'h0000, then DEC DE.
  - Required: results 16'h00FF and 16'hFFFF.
- **Busy handshake**
  - Stimulus: hold `i_cmd_valid` high continuously with changing `i_cmd`/`i_pair` during an INC.
  - Required: only commands present on IDLE edges execute; `o_cmd_ready` is 0 during cycles 1–6; latched operands are unaffected.
- **Mid-op reset**
  - Stimulus: assert `i_reset` in cycle 4 of an INC HL.
  - Required: next cycle is IDLE, no lo-byte write, no `o_done`, `o_cmd_ready`=1, and all strobes are 0.

Source files
------------

// File: rtl/reg_pair_sequencer_if.sv
// rtl/reg_pair_sequencer_if.sv - command handshake and register-file bus for reg_pair_sequencer
//
// Purpose: bundles the decode-side command handshake and the byte-wide
// register-file strobes into one interface.
// Ports (signals):
//   i_cmd_valid/o_cmd_ready  command handshake
//   i_cmd, i_pair, i_wdata   operation, pair select, WRITE data {hi, lo}
//   o_done, o_result         completion pulse and 16-bit pair value
//   o_rf_rd_en, o_rf_wr_en   register-file read/write strobes
//   o_rf_addr, o_rf_data     register-file address / write data
//   i_rf_data                register-file read data (cycle after o_rf_rd_en)
// Modports: master = control unit + register file side, slave = sequencer.
interface reg_pair_sequencer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
);
    logic                       i_cmd_valid;
    logic                       o_cmd_ready;
    logic [1:0]                 i_cmd;
    logic [1:0]                 i_pair;
    logic [2*DATA_WIDTH-1:0]    i_wdata;
    logic                       o_done;
    logic [2*DATA_WIDTH-1:0]    o_result;
    logic                       o_rf_rd_en;
    logic                       o_rf_wr_en;
    logic [ADDRESS_WIDTH-1:0]   o_rf_addr;
    logic [DATA_WIDTH-1:0]      o_rf_data;
    logic [DATA_WIDTH-1:0]      i_rf_data;

    modport master (
        output i_cmd_valid, i_cmd, i_pair, i_wdata, i_rf_data,
        input  o_cmd_ready, o_done, o_result, o_rf_rd_en, o_rf_wr_en, o_rf_addr, o_rf_data
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_pair, i_wdata, i_rf_data,
        output o_cmd_ready, o_done, o_result, o_rf_rd_en, o_rf_wr_en, o_rf_addr, o_rf_data
    );
endinterface

// File: rtl/reg_pair_sequencer.sv
// rtl/reg_pair_sequencer.sv - serializes 16-bit register-pair ops into byte register-file accesses
//
// Purpose: accepts READ/WRITE/INC/DEC on a register pair (BC, DE, HL, AF) and
// turns it into hi-byte then lo-byte register-file reads and/or writes,
// finishing with a one-cycle o_done pulse carrying the pair value.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset
//   bus      reg_pair_sequencer_if.slave (command handshake + register-file bus)
module reg_pair_sequencer #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDRESS_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] F_MASK        = 8'hF0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    reg_pair_sequencer_if.slave  bus
);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_INC   = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_HI  = 3'd1,
        RD_LO  = 3'd2,
        CAP_LO = 3'd3,
        WR_HI  = 3'd4,
        WR_LO  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [1:0]              pair_q, pair_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [PW-1:0]           val_q, val_d;       // value to write / value read
    logic [PW-1:0]           result_q, result_d; // presented on o_result
    logic [PW-1:0]           raw_pair;
    logic [PW-1:0]           calc_pair;

    // AF is stored hi=A (7), lo=F (6); the other pairs are hi even, lo odd.
    function automatic logic [ADDRESS_WIDTH-1:0] hi_addr(input logic [1:0] pair);
        case (pair)
            2'b00:   hi_addr = ADDRESS_WIDTH'(0);
            2'b01:   hi_addr = ADDRESS_WIDTH'(2);
            2'b10:   hi_addr = ADDRESS_WIDTH'(4);
            default: hi_addr = ADDRESS_WIDTH'(7);
        endcase
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] lo_addr(input logic [1:0] pair);
        case (pair)
            2'b00:   lo_addr = ADDRESS_WIDTH'(1);
            2'b01:   lo_addr = ADDRESS_WIDTH'(3);
            2'b10:   lo_addr = ADDRESS_WIDTH'(5);
            default: lo_addr = ADDRESS_WIDTH'(6);
        endcase
    endfunction

    // The F mask is folded into the stored value before the write so that the
    // value reported on o_result is exactly what the pair now holds.
    function automatic logic [PW-1:0] mask_f(input logic [PW-1:0] v, input logic [1:0] pair);
        if (lo_addr(pair) == ADDRESS_WIDTH'(6)) begin
            mask_f = {v[PW-1:DATA_WIDTH], v[DATA_WIDTH-1:0] & F_MASK};
        end else begin
            mask_f = v;
        end
    endfunction

    assign raw_pair = {hi_q, bus.i_rf_data};

    always_comb begin
        calc_pair = raw_pair;
        case (cmd_q)
            CMD_INC:   calc_pair = raw_pair + PW'(1);
            2'b11:     calc_pair = raw_pair - PW'(1);
            default:   calc_pair = raw_pair;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            pair_q   <= '0;
            hi_q     <= '0;
            val_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            pair_q   <= pair_d;
            hi_q     <= hi_d;
            val_q    <= val_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        pair_d   = pair_q;
        hi_d     = hi_q;
        val_d    = val_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    cmd_d   = bus.i_cmd;
                    pair_d  = bus.i_pair;
                    val_d   = mask_f(bus.i_wdata, bus.i_pair);
                    state_d = (bus.i_cmd == CMD_WRITE) ? WR_HI : RD_HI;
                end
            end
            RD_HI: state_d = RD_LO;
            RD_LO: begin
                hi_d    = bus.i_rf_data;
                state_d = CAP_LO;
            end
            CAP_LO: begin
                if (cmd_q == CMD_READ) begin
                    val_d    = raw_pair;
                    result_d = raw_pair;
                    state_d  = DONE;
                end else begin
                    val_d    = mask_f(calc_pair, pair_q);
                    state_d  = WR_HI;
                end
            end
            WR_HI: state_d = WR_LO;
            WR_LO: begin
                result_d = val_q;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs, decoded from state only
    always_comb begin
        bus.o_cmd_ready = 1'b0;
        bus.o_done      = 1'b0;
        bus.o_rf_rd_en  = 1'b0;
        bus.o_rf_wr_en  = 1'b0;
        bus.o_rf_addr   = '0;
        bus.o_rf_data   = '0;
        case (state_q)
            IDLE:  bus.o_cmd_ready = 1'b1;
            RD_HI: begin
                bus.o_rf_rd_en = 1'b1;
                bus.o_rf_addr  = hi_addr(pair_q);
            end
            RD_LO: begin
                bus.o_rf_rd_en = 1'b1;
                bus.o_rf_addr  = lo_addr(pair_q);
            end
            WR_HI: begin
                bus.o_rf_wr_en = 1'b1;
                bus.o_rf_addr  = hi_addr(pair_q);
                bus.o_rf_data  = val_q[PW-1:DATA_WIDTH];
            end
            WR_LO: begin
                bus.o_rf_wr_en = 1'b1;
                bus.o_rf_addr  = lo_addr(pair_q);
                bus.o_rf_data  = val_q[DATA_WIDTH-1:0];
            end
            DONE:    bus.o_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_result = result_q;
endmodule

// File: tb/tb_reg_pair_sequencer.sv
// tb/tb_reg_pair_sequencer.sv - directed self-checking bench for reg_pair_sequencer
module tb_reg_pair_sequencer;
    localparam logic [1:0] C_READ = 2'b00, C_WRITE = 2'b01, C_INC = 2'b10, C_DEC = 2'b11;
    localparam logic [1:0] P_BC = 2'b00, P_DE = 2'b01, P_HL = 2'b10, P_AF = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    reg_pair_sequencer_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) bus ();

    reg_pair_sequencer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .F_MASK(8'hF0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: registered read, data valid the cycle after rd_en.
    logic [7:0] mem [0:7];
    logic [7:0] rf_rdata = 8'h00;
    logic       pl_en;
    logic [2:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.o_rf_wr_en) mem[bus.o_rf_addr] <= bus.o_rf_data;
        if (bus.o_rf_rd_en) rf_rdata <= mem[bus.o_rf_addr];
    end
    assign bus.i_rf_data = rf_rdata;

    logic        cap_rd    [0:9];
    logic        cap_wr    [0:9];
    logic        cap_ready [0:9];
    logic        cap_done  [0:9];
    logic [2:0]  cap_addr  [0:9];
    logic [7:0]  cap_data  [0:9];
    logic [15:0] cap_res   [0:9];

    task automatic sample(input int c);
        cap_rd[c]    = bus.o_rf_rd_en;
        cap_wr[c]    = bus.o_rf_wr_en;
        cap_ready[c] = bus.o_cmd_ready;
        cap_done[c]  = bus.o_done;
        cap_addr[c]  = bus.o_rf_addr;
        cap_data[c]  = bus.o_rf_data;
        cap_res[c]   = bus.o_result;
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue in cycle 0 and record cycles 1..7; returns at the negedge of cycle 7.
    task automatic run_op(input logic [1:0] cmd, input logic [1:0] pair, input logic [15:0] wdata);
        bus.i_cmd = cmd; bus.i_pair = pair; bus.i_wdata = wdata; bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1) bus.i_cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_cmd_ready !== 1'b1 || bus.o_done !== 1'b0 || bus.o_rf_rd_en !== 1'b0 || bus.o_rf_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b done=%b rd=%b wr=%b exp 1 0 0 0", bus.o_cmd_ready, bus.o_done, bus.o_rf_rd_en, bus.o_rf_wr_en);
        end
        checks++;
        if (bus.o_rf_addr !== 3'd0 || bus.o_rf_data !== 8'h00 || bus.o_result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data addr=%h data=%h result=%h exp 0 00 0000", bus.o_rf_addr, bus.o_rf_data, bus.o_result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read;
        int nwr;
        preload(3'd4, 8'h12);
        preload(3'd5, 8'h34);
        run_op(C_READ, P_HL, 16'hFFFF);
        checks++;
        if (cap_rd[1] !== 1'b1 || cap_addr[1] !== 3'd4 || cap_rd[2] !== 1'b1 || cap_addr[2] !== 3'd5 || cap_rd[3] !== 1'b0) begin
            failures++;
            $display("FAIL read_strobes c1 rd=%b a=%0d c2 rd=%b a=%0d c3 rd=%b exp 1/4 1/5 0", cap_rd[1], cap_addr[1], cap_rd[2], cap_addr[2], cap_rd[3]);
        end
        checks++;
        if (cap_done[3] !== 1'b0 || cap_done[4] !== 1'b1 || cap_res[4] !== 16'h1234 || cap_done[5] !== 1'b0) begin
            failures++;
            $display("FAIL read_done done3=%b done4=%b res=%h done5=%b exp 0 1 1234 0", cap_done[3], cap_done[4], cap_res[4], cap_done[5]);
        end
        nwr = 0;
        for (int c = 1; c < 8; c++) if (cap_wr[c] !== 1'b0) nwr++;
        checks++;
        if (nwr != 0) begin
            failures++;
            $display("FAIL read_no_writes got %0d write cycles exp 0", nwr);
        end
        checks++;
        if (cap_ready[1] !== 1'b0 || cap_ready[4] !== 1'b0 || cap_ready[5] !== 1'b1) begin
            failures++;
            $display("FAIL read_ready c1=%b c4=%b c5=%b exp 0 0 1", cap_ready[1], cap_ready[4], cap_ready[5]);
        end
        checks++;
        if (cap_res[6] !== 16'h1234 || cap_addr[5] !== 3'd0 || cap_data[3] !== 8'h00) begin
            failures++;
            $display("FAIL read_hold res6=%h addr5=%h data3=%h exp 1234 0 00", cap_res[6], cap_addr[5], cap_data[3]);
        end
    endtask

    task automatic test_write_af;
        run_op(C_WRITE, P_AF, 16'hABCD);
        checks++;
        if (cap_wr[1] !== 1'b1 || cap_addr[1] !== 3'd7 || cap_data[1] !== 8'hAB) begin
            failures++;
            $display("FAIL wr_af_hi wr=%b addr=%0d data=%h exp 1 7 AB", cap_wr[1], cap_addr[1], cap_data[1]);
        end
        checks++;
        if (cap_wr[2] !== 1'b1 || cap_addr[2] !== 3'd6 || cap_data[2] !== 8'hC0 || cap_rd[1] !== 1'b0) begin
            failures++;
            $display("FAIL wr_af_lo wr=%b addr=%0d data=%h rd1=%b exp 1 6 C0 0", cap_wr[2], cap_addr[2], cap_data[2], cap_rd[1]);
        end
        checks++;
        if (cap_done[3] !== 1'b1 || cap_res[3] !== 16'hABC0 || cap_ready[4] !== 1'b1 || mem[6] !== 8'hC0) begin
            failures++;
            $display("FAIL wr_af_done done=%b res=%h ready4=%b f=%h exp 1 ABC0 1 C0", cap_done[3], cap_res[3], cap_ready[4], mem[6]);
        end
    endtask

    task automatic test_inc_wrap;
        preload(3'd0, 8'hFF);
        preload(3'd1, 8'hFF);
        run_op(C_INC, P_BC, 16'h0000);
        checks++;
        if (cap_rd[3] !== 1'b0 || cap_wr[3] !== 1'b0 || cap_wr[4] !== 1'b1 || cap_addr[4] !== 3'd0 || cap_data[4] !== 8'h00) begin
            failures++;
            $display("FAIL inc_wr_hi c3 rd=%b wr=%b c4 wr=%b addr=%0d data=%h exp 0 0 1 0 00", cap_rd[3], cap_wr[3], cap_wr[4], cap_addr[4], cap_data[4]);
        end
        checks++;
        if (cap_wr[5] !== 1'b1 || cap_addr[5] !== 3'd1 || cap_data[5] !== 8'h00) begin
            failures++;
            $display("FAIL inc_wr_lo wr=%b addr=%0d data=%h exp 1 1 00", cap_wr[5], cap_addr[5], cap_data[5]);
        end
        checks++;
        if (cap_done[6] !== 1'b1 || cap_res[6] !== 16'h0000 || cap_done[5] !== 1'b0 || mem[0] !== 8'h00 || mem[1] !== 8'h00) begin
            failures++;
            $display("FAIL inc_done done=%b res=%h done5=%b bc=%h%h exp 1 0000 0 0000", cap_done[6], cap_res[6], cap_done[5], mem[0], mem[1]);
        end
    endtask

    task automatic test_inc_af;
        preload(3'd7, 8'h12);
        preload(3'd6, 8'h0E);
        run_op(C_INC, P_AF, 16'h0000);
        checks++;
        if (cap_addr[1] !== 3'd7 || cap_addr[2] !== 3'd6 || cap_data[5] !== 8'h00 || cap_data[4] !== 8'h12) begin
            failures++;
            $display("FAIL inc_af_bus a1=%0d a2=%0d d4=%h d5=%h exp 7 6 12 00", cap_addr[1], cap_addr[2], cap_data[4], cap_data[5]);
        end
        checks++;
        if (cap_res[6] !== 16'h1200) begin
            failures++;
            $display("FAIL inc_af_result got %h exp 1200", cap_res[6]);
        end
    endtask

    task automatic test_dec;
        preload(3'd2, 8'h01);
        preload(3'd3, 8'h00);
        run_op(C_DEC, P_DE, 16'h0000);
        checks++;
        if (cap_data[4] !== 8'h00 || cap_data[5] !== 8'hFF || cap_addr[4] !== 3'd2 || cap_addr[5] !== 3'd3 || cap_res[6] !== 16'h00FF) begin
            failures++;
            $display("FAIL dec_borrow d4=%h d5=%h a4=%0d a5=%0d res=%h exp 00 FF 2 3 00FF", cap_data[4], cap_data[5], cap_addr[4], cap_addr[5], cap_res[6]);
        end
        preload(3'd2, 8'h00);
        preload(3'd3, 8'h00);
        run_op(C_DEC, P_DE, 16'h0000);
        checks++;
        if (cap_res[6] !== 16'hFFFF || cap_done[6] !== 1'b1 || mem[2] !== 8'hFF || mem[3] !== 8'hFF) begin
            failures++;
            $display("FAIL dec_wrap res=%h done=%b de=%h%h exp FFFF 1 FFFF", cap_res[6], cap_done[6], mem[2], mem[3]);
        end
    endtask

    task automatic test_busy;
        int nready, nwr;
        preload(3'd4, 8'h00);
        preload(3'd5, 8'hFF);
        bus.i_cmd = C_INC; bus.i_pair = P_HL; bus.i_wdata = 16'h0000; bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            sample(c);
            // Garbage while busy; a READ DE is on the bus at the IDLE edge ending cycle 7.
            if (c < 7) begin
                bus.i_cmd = C_WRITE; bus.i_pair = 2'(c); bus.i_wdata = 16'h5550 + 16'(c);
            end else if (c == 7) begin
                bus.i_cmd = C_READ; bus.i_pair = P_DE;
            end else if (c == 8) begin
                bus.i_cmd_valid = 1'b0;
            end
        end
        nready = 0;
        nwr = 0;
        for (int c = 1; c < 7; c++) begin
            if (cap_ready[c] !== 1'b0) nready++;
            if (cap_wr[c] === 1'b1) nwr++;
        end
        checks++;
        if (nready != 0 || cap_ready[7] !== 1'b1) begin
            failures++;
            $display("FAIL busy_ready high_in_busy=%0d ready7=%b exp 0 1", nready, cap_ready[7]);
        end
        checks++;
        if (nwr != 2 || cap_addr[4] !== 3'd4 || cap_data[4] !== 8'h01 || cap_addr[5] !== 3'd5 || cap_data[5] !== 8'h00) begin
            failures++;
            $display("FAIL busy_writes n=%0d a4=%0d d4=%h a5=%0d d5=%h exp 2 4 01 5 00", nwr, cap_addr[4], cap_data[4], cap_addr[5], cap_data[5]);
        end
        checks++;
        if (cap_done[6] !== 1'b1 || cap_res[6] !== 16'h0100 || mem[0] !== 8'h00 || mem[1] !== 8'h00) begin
            failures++;
            $display("FAIL busy_done done=%b res=%h bc=%h%h exp 1 0100 0000", cap_done[6], cap_res[6], mem[0], mem[1]);
        end
        checks++;
        if (cap_rd[8] !== 1'b1 || cap_addr[8] !== 3'd2 || cap_rd[9] !== 1'b1 || cap_addr[9] !== 3'd3) begin
            failures++;
            $display("FAIL busy_next_cmd rd8=%b a8=%0d rd9=%b a9=%0d exp 1 2 1 3", cap_rd[8], cap_addr[8], cap_rd[9], cap_addr[9]);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_midop_reset;
        preload(3'd4, 8'h12);
        preload(3'd5, 8'h34);
        bus.i_cmd = C_INC; bus.i_pair = P_HL; bus.i_wdata = 16'h0000; bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1) bus.i_cmd_valid = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) rst = 1'b0;
        end
        checks++;
        if (cap_wr[4] !== 1'b1 || cap_addr[4] !== 3'd4 || cap_data[4] !== 8'h12) begin
            failures++;
            $display("FAIL midop_hi_write wr=%b addr=%0d data=%h exp 1 4 12", cap_wr[4], cap_addr[4], cap_data[4]);
        end
        checks++;
        if (cap_wr[5] !== 1'b0 || cap_rd[5] !== 1'b0 || cap_addr[5] !== 3'd0 || cap_data[5] !== 8'h00 || cap_ready[5] !== 1'b1) begin
            failures++;
            $display("FAIL midop_idle wr=%b rd=%b addr=%0d data=%h ready=%b exp 0 0 0 00 1", cap_wr[5], cap_rd[5], cap_addr[5], cap_data[5], cap_ready[5]);
        end
        checks++;
        if (cap_done[5] !== 1'b0 || cap_done[6] !== 1'b0 || cap_wr[6] !== 1'b0 || cap_res[5] !== 16'h0000 || mem[5] !== 8'h34) begin
            failures++;
            $display("FAIL midop_abort done5=%b done6=%b wr6=%b res=%h l=%h exp 0 0 0 0000 34", cap_done[5], cap_done[6], cap_wr[6], cap_res[5], mem[5]);
        end
    endtask

    initial begin
        rst = 1'b1;
        pl_en = 1'b0; pl_addr = 3'd0; pl_data = 8'h00;
        bus.i_cmd_valid = 1'b0; bus.i_cmd = 2'b00; bus.i_pair = 2'b00; bus.i_wdata = 16'h0000;
        test_reset();
        test_read();
        test_write_af();
        test_inc_wrap();
        test_inc_af();
        test_dec();
        test_busy();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
